// File: rtl/i2c_slv_regmap.sv
// I2C slave with a 2^REG_ADDR_SZ x DATA_I2C_SZ register map (pointer write, burst write, burst read).
// Optional feature: define I2C_SLV_NACK_INJ_EN to let I_NACK_INJ force a NACK of a matching address.
module i2c_slv_regmap #(
  parameter int                     ADDR_I2C_SZ = 7,
  parameter logic [ADDR_I2C_SZ-1:0] SLV_ADDR    = 7'h68,
  parameter int                     DATA_I2C_SZ = 8,
  parameter int                     REG_ADDR_SZ = 7,
  parameter logic [REG_ADDR_SZ-1:0] WHO_ADDR    = 7'h75,
  parameter logic [DATA_I2C_SZ-1:0] WHO_VAL     = 8'h68
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   IO_SCL,
  inout  wire                    IO_SDA,
  input  logic                   I_HOST_WE,
  input  logic [REG_ADDR_SZ-1:0] I_HOST_ADDR,
  input  logic [DATA_I2C_SZ-1:0] I_HOST_DATA,
  output logic [DATA_I2C_SZ-1:0] O_HOST_DATA,
  output logic                   O_WR_STB,
  output logic [REG_ADDR_SZ-1:0] O_WR_ADDR,
  output logic [DATA_I2C_SZ-1:0] O_WR_DATA,
  output logic                   O_BUSY,
  input  logic                   I_NACK_INJ
);

  localparam int         NREG     = 2 ** REG_ADDR_SZ;
  localparam int         MSB      = DATA_I2C_SZ - 1;
  localparam logic [3:0] LAST_BIT = 4'(DATA_I2C_SZ - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, WAIT_P
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_I2C_SZ-1:0] sr_q, sr_d;
  logic [REG_ADDR_SZ-1:0] ptr_q, ptr_d;
  logic                   sda_oe_q, sda_oe_d;
  logic                   busy_q, busy_d;
  logic                   rw_q, rw_d;
  logic                   load_q, load_d;
  logic                   wr_stb_q, wr_stb_d;
  logic [REG_ADDR_SZ-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_I2C_SZ-1:0] wr_data_q, wr_data_d;
  logic [DATA_I2C_SZ-1:0] host_data_q;
  logic [DATA_I2C_SZ-1:0] regs_q [NREG];

  logic scl_s1_q, scl_s2_q, scl_p_q, sda_s1_q, sda_s2_q, sda_p_q;
  logic scl_rise, scl_fall, start_det, stop_det, nack_inj;
  logic [DATA_I2C_SZ-1:0] byte_in, rd_byte;

  always_ff @(posedge CLK) begin
    if (RST) begin
      {scl_s1_q, scl_s2_q, scl_p_q} <= 3'b111;
      {sda_s1_q, sda_s2_q, sda_p_q} <= 3'b111;
    end else begin
      {scl_s1_q, scl_s2_q, scl_p_q} <= {IO_SCL, scl_s1_q, scl_s2_q};
      {sda_s1_q, sda_s2_q, sda_p_q} <= {IO_SDA, sda_s1_q, sda_s2_q};
    end
  end

  assign scl_rise  = scl_s2_q & ~scl_p_q;
  assign scl_fall  = ~scl_s2_q & scl_p_q;
  assign start_det = scl_s2_q & scl_p_q & sda_p_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & scl_p_q & ~sda_p_q & sda_s2_q;
  assign byte_in   = {sr_q[MSB-1:0], sda_s2_q};
  assign rd_byte   = regs_q[ptr_q];

`ifdef I2C_SLV_NACK_INJ_EN
  assign nack_inj = I_NACK_INJ;
`else
  logic unused_nack_inj;
  assign nack_inj        = 1'b0;
  assign unused_nack_inj = I_NACK_INJ;
`endif

  // NOTE: every signal gets its hold value first so no path through this block infers a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    rw_d      = rw_q;
    load_d    = load_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (stop_det) begin
      state_d   = IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = '0;
      load_d    = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      sda_oe_d  = 1'b0;
      bit_cnt_d = '0;
      load_d    = 1'b0;
    end else begin
      unique case (state_q)
        ADDR, PTR, WR: if (scl_rise) begin
          sr_d      = byte_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            if (state_q == ADDR) begin
              if (byte_in[MSB -: ADDR_I2C_SZ] == SLV_ADDR && !nack_inj) begin
                state_d = ADDR_ACK;
                rw_d    = byte_in[0];
                busy_d  = 1'b1;
              end else begin
                state_d = WAIT_P;
                busy_d  = 1'b0;
              end
            end else if (state_q == PTR) begin
              ptr_d   = byte_in[REG_ADDR_SZ-1:0];
              state_d = PTR_ACK;
            end else begin
              wr_stb_d  = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = byte_in;
              ptr_d     = ptr_q + REG_ADDR_SZ'(1);
              state_d   = WR_ACK;
            end
          end
        end
        // First SCL fall drives the ACK low, the second ends the ACK clock.
        ADDR_ACK, PTR_ACK, WR_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else if (state_q == ADDR_ACK && rw_q) begin
            sr_d     = rd_byte << 1;
            sda_oe_d = ~rd_byte[MSB];
            state_d  = RD;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = (state_q == ADDR_ACK) ? PTR : WR;
          end
        end
        RD: if (scl_fall) begin
          load_d = 1'b0;
          if (load_q) begin
            sr_d     = rd_byte << 1;
            sda_oe_d = ~rd_byte[MSB];
          end else begin
            sr_d     = sr_q << 1;
            sda_oe_d = ~sr_q[MSB];
          end
        end else if (scl_rise) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = RD_ACK;
          end
        end
        RD_ACK: if (scl_fall) begin
          sda_oe_d = 1'b0;
        end else if (scl_rise) begin
          if (!sda_s2_q) begin
            ptr_d   = ptr_q + REG_ADDR_SZ'(1);
            load_d  = 1'b1;
            state_d = RD;
          end else begin
            state_d = WAIT_P;
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      rw_q        <= 1'b0;
      load_q      <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      host_data_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      rw_q        <= rw_d;
      load_q      <= load_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      host_data_q <= regs_q[I_HOST_ADDR];
    end
  end

  // NOTE: the register map is a reset flop array (it must come up with WHO_VAL), so it cannot map to RAM.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= (REG_ADDR_SZ'(i) == WHO_ADDR) ? WHO_VAL : '0;
    end else begin
      if (wr_stb_d && wr_addr_d != WHO_ADDR) regs_q[wr_addr_d] <= wr_data_d;
      // Host write is last so it wins a same-index collision with the master.
      if (I_HOST_WE) regs_q[I_HOST_ADDR] <= I_HOST_DATA;
    end
  end

  assign IO_SDA      = sda_oe_q ? 1'b0 : 1'bz;
  assign O_HOST_DATA = host_data_q;
  assign O_WR_STB    = wr_stb_q;
  assign O_WR_ADDR   = wr_addr_q;
  assign O_WR_DATA   = wr_data_q;
  assign O_BUSY      = busy_q;

endmodule

// File: tb/tb_i2c_slv_regmap.sv
// Directed bench for i2c_slv_regmap: a bit-banged I2C master on a pulled-up SDA line.
module tb_i2c_slv_regmap;

  localparam int Q = 12;  // quarter SCL period in CLK cycles

  logic       clk = 1'b0;
  logic       rst, m_scl, m_sda_low, host_we, nack_inj;
  logic [6:0] host_addr, wr_addr;
  logic [7:0] host_wdata, host_rdata, wr_data;
  logic       wr_stb, busy;
  wire        io_sda;

  int         n_chk = 0;
  int         n_fail = 0;
  int         stb_cnt = 0;
  logic [6:0] stb_addr = '0;
  logic [7:0] stb_data = '0;

  always #10 clk = ~clk;

  assign io_sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (io_sda);

  i2c_slv_regmap dut (
    .CLK(clk), .RST(rst), .IO_SCL(m_scl), .IO_SDA(io_sda),
    .I_HOST_WE(host_we), .I_HOST_ADDR(host_addr), .I_HOST_DATA(host_wdata),
    .O_HOST_DATA(host_rdata), .O_WR_STB(wr_stb), .O_WR_ADDR(wr_addr),
    .O_WR_DATA(wr_data), .O_BUSY(busy), .I_NACK_INJ(nack_inj)
  );

  always @(negedge clk) begin
    if (wr_stb) begin
      stb_cnt++;
      stb_addr = wr_addr;
      stb_data = wr_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_bit(input logic drv_low, output logic smp);
    m_sda_low = drv_low;
    wait_clk(Q);
    m_scl = 1'b1;
    wait_clk(Q);
    smp = io_sda;
    wait_clk(Q);
    m_scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0;
    wait_clk(Q);
    m_scl = 1'b1;
    wait_clk(2 * Q);
    m_sda_low = 1'b1;
    wait_clk(2 * Q);
    m_scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1;
    wait_clk(Q);
    m_scl = 1'b1;
    wait_clk(2 * Q);
    m_sda_low = 1'b0;
    wait_clk(2 * Q);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) i2c_bit(~b[i], s);
    i2c_bit(1'b0, s);
    ack = ~s;
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b0, s);
      d[i] = s;
    end
    i2c_bit(~nack, s);
  endtask

  task automatic host_wr(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic host_chk(input string tag, input logic [6:0] a, input logic [7:0] exp);
    @(negedge clk);
    host_addr = a;
    @(negedge clk);
    check(tag, host_rdata, exp);
  endtask

  task automatic setup_read(input string tag, input logic [7:0] ptr);
    logic a;
    i2c_start();
    wr_byte(8'hD0, a); check({tag, "_aw"}, a, 1'b1);
    wr_byte(ptr, a);   check({tag, "_ptr"}, a, 1'b1);
    i2c_start();
    wr_byte(8'hD1, a); check({tag, "_ar"}, a, 1'b1);
  endtask

  initial begin
    logic       a, s;
    logic [7:0] d;
    logic [7:0] burst_exp [6];
    int         stb0;

    burst_exp = '{8'hF0, 8'hB0, 8'hF0, 8'hB0, 8'hF0, 8'hB0};
    rst = 1'b1; m_scl = 1'b1; m_sda_low = 1'b0;
    host_we = 1'b0; host_addr = '0; host_wdata = '0; nack_inj = 1'b0;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(2);

    // Reset state
    check("rst_busy", busy, 1'b0);
    check("rst_stb", wr_stb, 1'b0);
    check("rst_wr_addr", wr_addr, 7'h00);
    check("rst_wr_data", wr_data, 8'h00);
    check("rst_host_data", host_rdata, 8'h00);
    check("rst_sda", io_sda, 1'b1);
    host_chk("rst_who_host", 7'h75, 8'h68);

    // Pointer + single byte write
    i2c_start();
    wr_byte(8'hD0, a); check("w_addr_ack", a, 1'b1);
    check("w_busy", busy, 1'b1);
    wr_byte(8'h1B, a); check("w_ptr_ack", a, 1'b1);
    wr_byte(8'h18, a); check("w_data_ack", a, 1'b1);
    i2c_stop();
    wait_clk(8);
    check("w_busy_after_stop", busy, 1'b0);
    check("w_stb_cnt", stb_cnt, 1);
    check("w_stb_addr", stb_addr, 7'h1B);
    check("w_stb_data", stb_data, 8'h18);
    host_chk("w_reg", 7'h1B, 8'h18);

    // Host preload then 6-byte burst read after repeated START
    for (int i = 0; i < 6; i++) host_wr(7'(8'h3B + i), burst_exp[i]);
    setup_read("burst", 8'h3B);
    for (int i = 0; i < 6; i++) begin
      rd_byte(i == 5, d);
      check("burst_byte", d, burst_exp[i]);
    end
    check("burst_busy", busy, 1'b1);
    i2c_stop();

    // Pointer wrap 0x7F -> 0x00
    host_wr(7'h7F, 8'hA5);
    host_wr(7'h00, 8'h3C);
    setup_read("wrap", 8'h7F);
    rd_byte(1'b0, d); check("wrap_7f", d, 8'hA5);
    rd_byte(1'b1, d); check("wrap_00", d, 8'h3C);
    i2c_stop();

    // WHO_AM_I is read-only to the master
    setup_read("who", 8'h75);
    rd_byte(1'b1, d); check("who_read", d, 8'h68);
    i2c_stop();
    stb0 = stb_cnt;
    i2c_start();
    wr_byte(8'hD0, a); wr_byte(8'h75, a);
    wr_byte(8'h55, a); check("who_wr_ack", a, 1'b1);
    i2c_stop();
    check("who_stb_cnt", stb_cnt, stb0 + 1);
    check("who_stb_addr", stb_addr, 7'h75);
    check("who_stb_data", stb_data, 8'h55);
    setup_read("who2", 8'h75);
    rd_byte(1'b1, d); check("who_readback", d, 8'h68);
    i2c_stop();

    // Foreign address 0x69: NACK, no drive, not busy
    stb0 = stb_cnt;
    i2c_start();
    wr_byte(8'hD2, a); check("mis_nack", a, 1'b0);
    check("mis_busy", busy, 1'b0);
    wr_byte(8'h00, a); check("mis_no_drive", a, 1'b0);
    check("mis_busy2", busy, 1'b0);
    i2c_stop();
    check("mis_no_stb", stb_cnt, stb0);

    // Address NACK injection
    nack_inj = 1'b1;
    i2c_start();
    wr_byte(8'hD0, a);
`ifdef I2C_SLV_NACK_INJ_EN
    check("inj_nack", a, 1'b0);
    check("inj_busy", busy, 1'b0);
`else
    check("inj_ignored", a, 1'b1);
    check("inj_busy", busy, 1'b1);
`endif
    i2c_stop();
    nack_inj = 1'b0;
    wait_clk(8);
    check("inj_busy_after_stop", busy, 1'b0);

    // Reset during the 4th bit of a read of 0x68 (bit is 0, slave drives low)
    setup_read("rstrd", 8'h75);
    for (int i = 0; i < 3; i++) i2c_bit(1'b0, s);
    m_sda_low = 1'b0;
    wait_clk(Q);
    m_scl = 1'b1;
    wait_clk(Q);
    check("rstrd_drive_low", io_sda, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("rstrd_sda_released", io_sda, 1'b1);
    check("rstrd_busy", busy, 1'b0);
    rst = 1'b0;
    wait_clk(Q);
    m_scl = 1'b0;
    wait_clk(Q);
    check("rstrd_still_released", io_sda, 1'b1);
    i2c_stop();
    host_chk("rstrd_reg_cleared", 7'h1B, 8'h00);
    setup_read("post_rst", 8'h75);
    rd_byte(1'b1, d); check("post_rst_who", d, 8'h68);
    i2c_stop();

    // Host port may overwrite WHO_AM_I
    host_wr(7'h75, 8'h12);
    host_chk("host_who_overwrite", 7'h75, 8'h12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_slv_regmap.md
# i2c_slv_regmap

Synthesizable, parametrised I2C slave with an internal register map, emulating an MPU-6050-class sensor on the same IO_SCL/IO_SDA bus as the I2C master. It replaces the fixed-delay ACK and shift tasks in simulation with a bus-accurate responder. It decodes START/STOP, matches its 7-bit address and handles register-pointer writes, burst writes and burst reads with auto-increment. A host-side port preloads sensor values and observes master writes.

## Interface
Parameters:
- ADDR_I2C_SZ, 7, I2C address width
- SLV_ADDR, 7'h68, own bus address
- DATA_I2C_SZ, 8, data byte width
- REG_ADDR_SZ, 7, register-pointer width (2^REG_ADDR_SZ registers)
- WHO_ADDR, 7'h75, WHO_AM_I register index
- WHO_VAL, 8'h68, WHO_AM_I reset/read-only value

Ports:
- CLK  in  1  system clock, 50 MHz
- RST  in  1  synchronous, active-high reset
- IO_SCL  in  1  I2C clock (slave never stretches)
- IO_SDA  inout  1  I2C data, open drain: driven 0 or 'z' only
- I_HOST_WE  in  1  host register write strobe
- I_HOST_ADDR  in  REG_ADDR_SZ  host write/read index
- I_HOST_DATA  in  DATA_I2C_SZ  host write data
- O_HOST_DATA  out  DATA_I2C_SZ  registered read of reg[I_HOST_ADDR]
- O_WR_STB  out  1  one-cycle pulse per byte written by the master
- O_WR_ADDR  out  REG_ADDR_SZ  register index of that write
- O_WR_DATA  out  DATA_I2C_SZ  data of that write
- O_BUSY  out  1  addressed transaction in progress
- I_NACK_INJ  in  1  force NACK of address phase (macro-dependent)

## Operation
- SCL and SDA pass through 2-flop synchronizers, then edge detect. START = SDA fall while SCL high; STOP = SDA rise while SCL high.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, WAIT_P.
  - START from any state: to ADDR with the bit counter cleared (repeated start).
  - STOP from any state: to IDLE.
  - ADDR shifts 8 bits on SCL rise, MSB first.
    - Address match, write: ACK, then PTR.
    - Address match, read: ACK, then RD.
    - Mismatch: WAIT_P, SDA released.
  - PTR: byte loads the pointer, then ACK, then WR.
  - WR: each byte is stored to reg[ptr] and pulses O_WR_STB; ACK; ptr+1.
  - RD: drives reg[ptr] MSB first. On SCL rise in RD_ACK, the master's bit is sampled:
    - ACK (0): ptr+1, back to RD.
    - NACK (1): to WAIT_P.
- Pointer arithmetic is modulo 2^REG_ADDR_SZ: 0x7F+1 wraps to 0x00.
- WHO_ADDR is read-only to the master: the write is ACKed and O_WR_STB pulses, but the register is unchanged. The host port can overwrite it.
- Simultaneous host write and master write to the same index in one cycle: the host value is stored, and O_WR_STB still reports the master data.
- O_BUSY is 1 from ADDR_ACK (match) until STOP, START-to-mismatch or reset.

## Timing
- Reset values:
  - IO_SDA released ('z')
  - O_BUSY=0, O_WR_STB=0, O_WR_ADDR=0, O_WR_DATA=0, O_HOST_DATA=0
  - pointer=0, FSM=IDLE
  - all registers 0 except reg[WHO_ADDR]=WHO_VAL
- Reset asserted mid-transfer: SDA is released on the first CLK edge with RST=1. The slave then ignores the bus until the next START.
- Bus event latency: ≤3 CLK from a pin edge to the internal event (2 sync + 1 detect).
- SDA drive changes only ≤4 CLK after a detected SCL fall. It is held through the following SCL high. At 400 kHz the SCL low phase is ≥65 CLK.
- O_WR_STB pulses 1 CLK after the 8th data-bit SCL rise is detected.
- O_HOST_DATA latency: 1 CLK.

## Configuration
- I2C_SLV_NACK_INJ_EN:
  - Defined: I_NACK_INJ=1, sampled at the 8th address bit, makes a matching address get NACKed (SDA released) and go to WAIT_P. This exercises the master's O_ACK_FL/O_CNT_RS_ACK_FL path.
  - Undefined: I_NACK_INJ is ignored and the logic is not generated.

## Test plan
- Master writes 0x68+W, ptr 0x1B, data 0x18 -> three ACKs; O_WR_STB once with ADDR=0x1B, DATA=0x18; reg[0x1B]=0x18.
- Host preloads 0x3B..0x40 = F0,B0,F0,B0,F0,B0. Master sets ptr 0x3B, repeated START, reads 6 bytes, NACKing the last -> bus bytes F0 B0 F0 B0 F0 B0.
- Master sets ptr 0x7F and burst reads 2 -> reg[0x7F] then reg[0x00] (wrap).
- Read of 0x75 after reset -> 0x68. Master write 0x55 to 0x75 is ACKed, and a readback still gives 0x68.
- Address 0x69 -> NACK, O_BUSY stays 0, no SDA drive until the next START.
- RST asserted during the 4th bit of a read -> SDA is 'z' the next cycle, O_BUSY=0. With I2C_SLV_NACK_INJ_EN defined and I_NACK_INJ=1, 0x68+W -> NACK.
